// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared types and default constants for the UART command sequencer.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OP,
    DHI,
    DLO,
    CHK,
    ISSUE
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int unsigned CLK_PER_BIT     = 2604;
  // 20 bit times of silence inside a frame aborts it
  localparam int unsigned TIMEOUT_CYC_DEF = 20 * CLK_PER_BIT;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Receiver-side handshake plus command valid/ack bundle for the sequencer.
// slave  : the sequencer itself
// master : receiver + command consumer side
interface uart_cmd_sequencer_if;

  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_rdy_clr;
  logic        cmd_vld;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cmd_ack;
  logic        frame_err;
  logic        busy;

  modport slave (
    input  rx_rdy, rx_data, cmd_ack,
    output rx_rdy_clr, cmd_vld, cmd_op, cmd_data, frame_err, busy
  );

  modport master (
    output rx_rdy, rx_data, cmd_ack,
    input  rx_rdy_clr, cmd_vld, cmd_op, cmd_data, frame_err, busy
  );

endinterface

// File: rtl/uart_cmd_sequencer_timeout.sv
// Inter-byte timeout counter: loadable up-counter with synchronous clear,
// count enable and a terminal-count flag.
module uart_cmd_timeout #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned TERMINAL = 52080
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;

  // Count register; clear has priority over load, load over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/uart_cmd_sequencer.sv
// UART command framer: sync, opcode, data_hi, data_lo [, checksum].
// Build option: define CHECKSUM_EN for the 5-byte frame with an 8-bit
// additive checksum over opcode and data bytes.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                 clk,
  input logic                 rst,
  uart_cmd_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] lo_q, lo_d;
  logic       clr_q;
  logic       err_q, err_d;
  logic       in_frame;
  logic       accept;
  logic       tc;
  logic       timeout_hit;
  logic       cnt_clear;
`ifdef CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  // Byte acceptance (masked while the clear pulse is out) and timeout qualification
  always_comb begin
    in_frame    = (state_q == OP) || (state_q == DHI) ||
                  (state_q == DLO) || (state_q == CHK);
    accept      = bus.rx_rdy & ~clr_q & (in_frame | (state_q == IDLE));
    timeout_hit = tc & in_frame & ~accept;
    cnt_clear   = accept | ~in_frame | timeout_hit;
  end

  uart_cmd_timeout #(
    .WIDTH    (CNT_W),
    .TERMINAL (TIMEOUT_CYC)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (cnt_clear),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (in_frame),
    .tc_o       (tc)
  );

  // Next-state, capture and error decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = 1'b0;
`ifdef CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (timeout_hit) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (bus.rx_data == SYNC_BYTE)) state_d = OP;
        end
        OP: begin
          if (accept) begin
            op_d    = bus.rx_data;
`ifdef CHECKSUM_EN
            sum_d   = bus.rx_data;
`endif
            state_d = DHI;
          end
        end
        DHI: begin
          if (accept) begin
            hi_d    = bus.rx_data;
`ifdef CHECKSUM_EN
            sum_d   = sum_q + bus.rx_data;
`endif
            state_d = DLO;
          end
        end
        DLO: begin
          if (accept) begin
            lo_d    = bus.rx_data;
`ifdef CHECKSUM_EN
            sum_d   = sum_q + bus.rx_data;
            state_d = CHK;
`else
            state_d = ISSUE;
`endif
          end
        end
`ifdef CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (bus.rx_data == sum_q) begin
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
`endif
        ISSUE: begin
          if (bus.cmd_ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, capture registers and registered handshake pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      clr_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      clr_q   <= accept;
      err_q   <= err_d;
`ifdef CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign bus.rx_rdy_clr = clr_q;
  assign bus.cmd_vld    = (state_q == ISSUE);
  assign bus.cmd_op     = op_q;
  assign bus.cmd_data   = {hi_q, lo_q};
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
